// File: rtl/multicycle_core_ctrl.sv
// Multicycle control FSM: sequences fetch/decode/execute/mem/writeback,
// owns the PC and IR, bounds memory waits and parks in a sticky fault state.
module multicycle_core_ctrl #(
  parameter int              PC_W     = 32,
  parameter int              XLEN     = 64,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              MAX_WAIT = 15
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic [31:0]     imem_rdata,
  output logic            dmem_req,
  output logic            dmem_we,
  input  logic            dmem_ready,
  input  logic            alu_zero,
  input  logic [XLEN-1:0] imm,
  output logic [PC_W-1:0] pc,
  output logic [31:0]     ir,
  output logic [1:0]      alu_op,
  output logic            alu_src,
  output logic            reg_write,
  output logic            mem_to_reg,
  output logic [2:0]      state,
  output logic            retire,
  output logic            fault
);

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEM       = 3'd3,
    S_WRITEBACK = 3'd4,
    S_FAULT     = 3'd7
  } state_t;

  localparam logic [6:0]  OP_R      = 7'b0110011;
  localparam logic [6:0]  OP_I      = 7'b0010011;
  localparam logic [6:0]  OP_LOAD   = 7'b0000011;
  localparam logic [6:0]  OP_STORE  = 7'b0100011;
  localparam logic [6:0]  OP_BRANCH = 7'b1100011;
  localparam logic [31:0] NOP_INSN  = 32'h0000_0013;
  // Last counter value at which a still-low ready forces the fault.
  localparam logic [7:0]  WAIT_LAST = 8'(MAX_WAIT - 1);

  state_t          state_reg;
  logic [PC_W-1:0] pc_reg;
  logic [31:0]     ir_reg;
  logic [7:0]      wait_cnt_reg;
  logic            imem_req_reg;
  logic            dmem_req_reg;
  logic            dmem_we_reg;
  logic            reg_write_reg;
  logic            mem_to_reg_reg;
  logic            retire_reg;
  logic            fault_reg;

  logic [6:0]      opcode;
  logic            is_r, is_i, is_load, is_store, is_branch, is_legal;
  logic [PC_W-1:0] pc_plus4;
  logic [PC_W-1:0] branch_target;

  assign opcode    = ir_reg[6:0];
  assign is_r      = (opcode == OP_R);
  assign is_i      = (opcode == OP_I);
  assign is_load   = (opcode == OP_LOAD);
  assign is_store  = (opcode == OP_STORE);
  assign is_branch = (opcode == OP_BRANCH);
  assign is_legal  = is_r | is_i | is_load | is_store | is_branch;

  always_comb begin
    alu_op = 2'b00;
    if (is_branch)
      alu_op = 2'b01;
    else if (is_r || is_i)
      alu_op = 2'b10;
  end
  assign alu_src = is_i | is_load | is_store;

  assign pc_plus4      = pc_reg + PC_W'(4);
  assign branch_target = pc_reg + imm[PC_W-1:0];

  generate
    if (XLEN > PC_W) begin : g_imm_hi
      logic unused_imm_hi;
      assign unused_imm_hi = ^imm[XLEN-1:PC_W];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= S_FETCH;
      pc_reg         <= RESET_PC;
      ir_reg         <= NOP_INSN;
      wait_cnt_reg   <= '0;
      imem_req_reg   <= 1'b1;
      dmem_req_reg   <= 1'b0;
      dmem_we_reg    <= 1'b0;
      reg_write_reg  <= 1'b0;
      mem_to_reg_reg <= 1'b0;
      retire_reg     <= 1'b0;
      fault_reg      <= 1'b0;
    end else begin
      // Pulsed outputs default low; the transitions below raise them.
      retire_reg     <= 1'b0;
      reg_write_reg  <= 1'b0;
      mem_to_reg_reg <= 1'b0;
      case (state_reg)
        S_FETCH: begin
          if (imem_ready) begin
            ir_reg       <= imem_rdata;
            imem_req_reg <= 1'b0;
            state_reg    <= S_DECODE;
          end else if (wait_cnt_reg == WAIT_LAST) begin
            imem_req_reg <= 1'b0;
            fault_reg    <= 1'b1;
            state_reg    <= S_FAULT;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 8'd1;
          end
        end
        S_DECODE: begin
          if (is_legal) begin
            state_reg <= S_EXECUTE;
          end else begin
            fault_reg <= 1'b1;
            state_reg <= S_FAULT;
          end
        end
        S_EXECUTE: begin
          if (is_load || is_store) begin
            dmem_req_reg <= 1'b1;
            dmem_we_reg  <= is_store;
            wait_cnt_reg <= '0;
            state_reg    <= S_MEM;
          end else if (is_branch) begin
            if (alu_zero && (branch_target[1:0] != 2'b00)) begin
              fault_reg <= 1'b1;
              state_reg <= S_FAULT;
            end else begin
              pc_reg       <= alu_zero ? branch_target : pc_plus4;
              retire_reg   <= 1'b1;
              imem_req_reg <= 1'b1;
              wait_cnt_reg <= '0;
              state_reg    <= S_FETCH;
            end
          end else begin
            reg_write_reg <= 1'b1;
            state_reg     <= S_WRITEBACK;
          end
        end
        S_MEM: begin
          if (dmem_ready) begin
            dmem_req_reg <= 1'b0;
            dmem_we_reg  <= 1'b0;
            if (is_store) begin
              pc_reg       <= pc_plus4;
              retire_reg   <= 1'b1;
              imem_req_reg <= 1'b1;
              wait_cnt_reg <= '0;
              state_reg    <= S_FETCH;
            end else begin
              reg_write_reg  <= 1'b1;
              mem_to_reg_reg <= 1'b1;
              state_reg      <= S_WRITEBACK;
            end
          end else if (wait_cnt_reg == WAIT_LAST) begin
            dmem_req_reg <= 1'b0;
            dmem_we_reg  <= 1'b0;
            fault_reg    <= 1'b1;
            state_reg    <= S_FAULT;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 8'd1;
          end
        end
        S_WRITEBACK: begin
          pc_reg       <= pc_plus4;
          retire_reg   <= 1'b1;
          imem_req_reg <= 1'b1;
          wait_cnt_reg <= '0;
          state_reg    <= S_FETCH;
        end
        S_FAULT: begin
          fault_reg <= 1'b1;
        end
        default: begin
          imem_req_reg <= 1'b0;
          dmem_req_reg <= 1'b0;
          dmem_we_reg  <= 1'b0;
          fault_reg    <= 1'b1;
          state_reg    <= S_FAULT;
        end
      endcase
    end
  end

  assign state      = state_reg;
  assign pc         = pc_reg;
  assign imem_addr  = pc_reg;
  assign ir         = ir_reg;
  assign imem_req   = imem_req_reg;
  assign dmem_req   = dmem_req_reg;
  assign dmem_we    = dmem_we_reg;
  assign reg_write  = reg_write_reg;
  assign mem_to_reg = mem_to_reg_reg;
  assign retire     = retire_reg;
  assign fault      = fault_reg;

endmodule

// File: tb/tb_multicycle_core_ctrl.sv
// Directed bench for multicycle_core_ctrl: per-cycle control vectors and PC
// values for each instruction class, wait limits, faults and resets.
module tb_multicycle_core_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_ready;
  logic        alu_zero;
  logic [63:0] imm;
  logic [31:0] pc;
  logic [31:0] ir;
  logic [1:0]  alu_op;
  logic        alu_src;
  logic        reg_write;
  logic        mem_to_reg;
  logic [2:0]  state;
  logic        retire;
  logic        fault;

  multicycle_core_ctrl #(
    .PC_W(32), .XLEN(64), .RESET_PC(32'h0), .MAX_WAIT(15)
  ) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
    .alu_zero(alu_zero), .imm(imm), .pc(pc), .ir(ir),
    .alu_op(alu_op), .alu_src(alu_src), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
    .state(state), .retire(retire), .fault(fault)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] I_ADD = 32'h0020_81B3;
  localparam logic [31:0] I_LD  = 32'h0000_B183;
  localparam logic [31:0] I_SD  = 32'h0011_3023;
  localparam logic [31:0] I_BEQ = 32'h0000_0063;
  localparam logic [31:0] I_BAD = 32'h0000_007F;

  // {state, imem_req, dmem_req, dmem_we, reg_write, mem_to_reg, retire, fault}
  localparam logic [9:0] V_F   = {3'd0, 7'b1000000};
  localparam logic [9:0] V_FR  = {3'd0, 7'b1000010};
  localparam logic [9:0] V_D   = {3'd1, 7'b0000000};
  localparam logic [9:0] V_E   = {3'd2, 7'b0000000};
  localparam logic [9:0] V_ML  = {3'd3, 7'b0100000};
  localparam logic [9:0] V_MS  = {3'd3, 7'b0110000};
  localparam logic [9:0] V_WB  = {3'd4, 7'b0001000};
  localparam logic [9:0] V_WBL = {3'd4, 7'b0001100};
  localparam logic [9:0] V_FLT = {3'd7, 7'b0000001};

  int total = 0;
  int bad   = 0;
  logic [9:0] obs;
  logic [9:0] trace [$];

  assign obs = {state, imem_req, dmem_req, dmem_we, reg_write, mem_to_reg, retire, fault};

  // Record this cycle's controls, then advance to just after the next edge.
  task automatic cyc();
    trace.push_back(obs);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; imem_ready = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    dmem_ready = 1'b1; alu_zero = 1'b0; imm = '0;
    repeat (2) @(negedge clk);
    total++; if (obs !== V_F) begin $display("FAIL reset_ctl got=%b want=%b", obs, V_F); bad++; end
    total++; if (pc !== 32'h0) begin $display("FAIL reset_pc got=%h want=%h", pc, 32'h0); bad++; end
    total++; if (ir !== 32'h13) begin $display("FAIL reset_ir got=%h want=%h", ir, 32'h13); bad++; end
    imem_ready = 1'b0; dmem_ready = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    total++; if (obs !== V_F) begin $display("FAIL reset_first_edge got=%b want=%b", obs, V_F); bad++; end
    total++; if (imem_addr !== 32'h0) begin $display("FAIL reset_addr got=%h want=%h", imem_addr, 32'h0); bad++; end
    $display("[reset] pc=%h ir=%h", pc, ir);
  endtask

  task automatic test_add();
    logic [9:0] e [4] = '{V_F, V_D, V_E, V_WB};
    trace.delete();
    imem_rdata = I_ADD; imem_ready = 1'b1; cyc();
    imem_ready = 1'b0;
    total++; if (ir !== I_ADD) begin $display("FAIL add_ir got=%h want=%h", ir, I_ADD); bad++; end
    total++; if ({alu_op, alu_src} !== 3'b100) begin $display("FAIL add_dec got=%b want=100", {alu_op, alu_src}); bad++; end
    cyc(); cyc(); cyc();
    for (int i = 0; i < 4; i++) begin
      total++; if (trace[i] !== e[i]) begin $display("FAIL add_cyc%0d got=%b want=%b", i + 1, trace[i], e[i]); bad++; end
    end
    total++; if (obs !== V_FR) begin $display("FAIL add_retire got=%b want=%b", obs, V_FR); bad++; end
    total++; if (pc !== 32'h4) begin $display("FAIL add_pc got=%h want=%h", pc, 32'h4); bad++; end
    $display("[add] pc=%h", pc);
    cyc();
  endtask

  task automatic test_load();
    logic [9:0] e [8] = '{V_F, V_D, V_E, V_ML, V_ML, V_ML, V_ML, V_WBL};
    trace.delete();
    imem_rdata = I_LD; imem_ready = 1'b1; dmem_ready = 1'b1; cyc();
    // Fetch ready keeps toggling garbage in while no fetch is requested.
    imem_rdata = I_BAD;
    total++; if ({alu_op, alu_src} !== 3'b001) begin $display("FAIL ld_dec got=%b want=001", {alu_op, alu_src}); bad++; end
    cyc();
    dmem_ready = 1'b0; cyc();
    cyc(); cyc(); cyc();
    dmem_ready = 1'b1; cyc();
    dmem_ready = 1'b0; imem_ready = 1'b0; cyc();
    for (int i = 0; i < 8; i++) begin
      total++; if (trace[i] !== e[i]) begin $display("FAIL ld_cyc%0d got=%b want=%b", i + 1, trace[i], e[i]); bad++; end
    end
    total++; if (obs !== V_FR) begin $display("FAIL ld_retire got=%b want=%b", obs, V_FR); bad++; end
    total++; if (pc !== 32'h8) begin $display("FAIL ld_pc got=%h want=%h", pc, 32'h8); bad++; end
    total++; if (ir !== I_LD) begin $display("FAIL ld_ir_held got=%h want=%h", ir, I_LD); bad++; end
    $display("[load] pc=%h", pc);
    cyc();
  endtask

  task automatic test_branch();
    logic [63:0] imms [4] = '{64'h0000_0000_0000_00F8, 64'hFFFF_FFFF_FFFF_FFF8,
                              64'h0000_0000_0000_0008, 64'hFFFF_FFFF_FFFF_FFF8};
    logic        zs   [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic [31:0] pcs  [4] = '{32'h100, 32'hF8, 32'h100, 32'h104};
    logic [9:0]  e    [3] = '{V_F, V_D, V_E};
    for (int k = 0; k < 4; k++) begin
      trace.delete();
      imem_rdata = I_BEQ; imem_ready = 1'b1; imm = imms[k]; alu_zero = zs[k]; cyc();
      imem_ready = 1'b0;
      total++; if ({alu_op, alu_src} !== 3'b010) begin $display("FAIL br%0d_dec got=%b want=010", k, {alu_op, alu_src}); bad++; end
      cyc(); cyc();
      for (int i = 0; i < 3; i++) begin
        total++; if (trace[i] !== e[i]) begin $display("FAIL br%0d_cyc%0d got=%b want=%b", k, i + 1, trace[i], e[i]); bad++; end
      end
      total++; if (obs !== V_FR) begin $display("FAIL br%0d_retire got=%b want=%b", k, obs, V_FR); bad++; end
      total++; if (pc !== pcs[k]) begin $display("FAIL br%0d_pc got=%h want=%h", k, pc, pcs[k]); bad++; end
      $display("[branch] taken=%0b pc=%h", zs[k], pc);
      cyc();
    end
    alu_zero = 1'b0;
  endtask

  task automatic test_store_wrap();
    logic [9:0] e [4] = '{V_F, V_D, V_E, V_MS};
    trace.delete();
    imem_rdata = I_BEQ; imem_ready = 1'b1; imm = 64'hFFFF_FFFF_FFFF_FEF8; alu_zero = 1'b1; cyc();
    imem_ready = 1'b0; cyc(); cyc();
    alu_zero = 1'b0;
    total++; if (pc !== 32'hFFFF_FFFC) begin $display("FAIL sd_setup_pc got=%h want=%h", pc, 32'hFFFF_FFFC); bad++; end
    cyc();
    trace.delete();
    imem_rdata = I_SD; imem_ready = 1'b1; cyc();
    imem_ready = 1'b0;
    total++; if ({alu_op, alu_src} !== 3'b001) begin $display("FAIL sd_dec got=%b want=001", {alu_op, alu_src}); bad++; end
    cyc();
    dmem_ready = 1'b1; cyc(); cyc();
    dmem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      total++; if (trace[i] !== e[i]) begin $display("FAIL sd_cyc%0d got=%b want=%b", i + 1, trace[i], e[i]); bad++; end
    end
    total++; if (obs !== V_FR) begin $display("FAIL sd_retire got=%b want=%b", obs, V_FR); bad++; end
    total++; if (pc !== 32'h0) begin $display("FAIL sd_wrap_pc got=%h want=%h", pc, 32'h0); bad++; end
    $display("[store] pc=%h", pc);
    cyc();
  endtask

  // Entered mid-way: FETCH cycle 1 was the retire cycle, so the bench is in cycle 2.
  task automatic test_fetch_ready_wins();
    logic [9:0] want;
    trace.delete();
    imem_ready = 1'b0;
    repeat (13) cyc();
    imem_rdata = I_ADD; imem_ready = 1'b1; cyc();
    imem_ready = 1'b0; cyc(); cyc(); cyc();
    for (int i = 0; i < 17; i++) begin
      want = (i < 14) ? V_F : (i == 14) ? V_D : (i == 15) ? V_E : V_WB;
      total++; if (trace[i] !== want) begin $display("FAIL wait_cyc%0d got=%b want=%b", i + 2, trace[i], want); bad++; end
    end
    total++; if (pc !== 32'h4) begin $display("FAIL wait_pc got=%h want=%h", pc, 32'h4); bad++; end
    $display("[fetch_wait] ready on cycle 15, pc=%h", pc);
    cyc();
  endtask

  task automatic test_fetch_timeout();
    logic [9:0] want;
    trace.delete();
    imem_ready = 1'b0;
    repeat (14) cyc();
    imem_rdata = I_LD; imem_ready = 1'b1; dmem_ready = 1'b1;
    repeat (3) cyc();
    for (int i = 0; i < 17; i++) begin
      want = (i < 14) ? V_F : V_FLT;
      total++; if (trace[i] !== want) begin $display("FAIL ito_cyc%0d got=%b want=%b", i + 2, trace[i], want); bad++; end
    end
    total++; if (pc !== 32'h4) begin $display("FAIL ito_pc_frozen got=%h want=%h", pc, 32'h4); bad++; end
    total++; if (ir !== I_ADD) begin $display("FAIL ito_ir_frozen got=%h want=%h", ir, I_ADD); bad++; end
    rst = 1'b0; #1;
    total++; if (obs !== V_F) begin $display("FAIL ito_async_rst got=%b want=%b", obs, V_F); bad++; end
    total++; if (pc !== 32'h0) begin $display("FAIL ito_rst_pc got=%h want=%h", pc, 32'h0); bad++; end
    @(negedge clk);
    imem_ready = 1'b0; dmem_ready = 1'b0; rst = 1'b1;
    $display("[fetch_timeout] fault then reset, pc=%h", pc);
    cyc();
  endtask

  task automatic test_illegal();
    logic [9:0] e [4] = '{V_F, V_D, V_FLT, V_FLT};
    trace.delete();
    imem_rdata = I_BAD; imem_ready = 1'b1; cyc();
    imem_ready = 1'b0; cyc(); cyc(); cyc();
    for (int i = 0; i < 4; i++) begin
      total++; if (trace[i] !== e[i]) begin $display("FAIL ill_cyc%0d got=%b want=%b", i + 1, trace[i], e[i]); bad++; end
    end
    total++; if (pc !== 32'h0) begin $display("FAIL ill_pc got=%h want=%h", pc, 32'h0); bad++; end
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    total++; if (obs !== V_F) begin $display("FAIL ill_resume got=%b want=%b", obs, V_F); bad++; end
    total++; if (imem_addr !== 32'h0) begin $display("FAIL ill_resume_addr got=%h want=%h", imem_addr, 32'h0); bad++; end
    $display("[illegal] fault, resumed at %h", imem_addr);
  endtask

  task automatic test_misaligned_branch();
    logic [9:0] e [3] = '{V_F, V_D, V_E};
    trace.delete();
    imem_rdata = I_BEQ; imem_ready = 1'b1; imm = 64'h6; alu_zero = 1'b1; cyc();
    imem_ready = 1'b0; cyc(); cyc();
    alu_zero = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total++; if (trace[i] !== e[i]) begin $display("FAIL mis_cyc%0d got=%b want=%b", i + 1, trace[i], e[i]); bad++; end
    end
    total++; if (obs !== V_FLT) begin $display("FAIL mis_fault got=%b want=%b", obs, V_FLT); bad++; end
    total++; if (pc !== 32'h0) begin $display("FAIL mis_pc got=%h want=%h", pc, 32'h0); bad++; end
    $display("[misaligned] pc=%h fault=%0b", pc, fault);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    cyc();
  endtask

  task automatic test_mem_timeout_and_reset();
    logic [9:0] want;
    trace.delete();
    imem_rdata = I_SD; imem_ready = 1'b1; dmem_ready = 1'b0; cyc();
    imem_ready = 1'b0; cyc(); cyc();
    repeat (15) cyc();
    for (int i = 0; i < 18; i++) begin
      want = (i == 0) ? V_F : (i == 1) ? V_D : (i == 2) ? V_E : V_MS;
      total++; if (trace[i] !== want) begin $display("FAIL dto_cyc%0d got=%b want=%b", i + 1, trace[i], want); bad++; end
    end
    total++; if (obs !== V_FLT) begin $display("FAIL dto_fault got=%b want=%b", obs, V_FLT); bad++; end
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    // Load abandoned mid-MEM: no writeback and no retire may follow.
    trace.delete();
    imem_rdata = I_LD; imem_ready = 1'b1; cyc();
    imem_ready = 1'b0; cyc(); cyc(); cyc(); cyc();
    rst = 1'b0; #1;
    total++; if (obs !== V_F) begin $display("FAIL mrst_async got=%b want=%b", obs, V_F); bad++; end
    @(negedge clk);
    rst = 1'b1; dmem_ready = 1'b1;
    trace.delete();
    repeat (3) cyc();
    dmem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total++; if (trace[i] !== V_F) begin $display("FAIL mrst_cyc%0d got=%b want=%b", i + 1, trace[i], V_F); bad++; end
    end
    total++; if (pc !== 32'h0) begin $display("FAIL mrst_pc got=%h want=%h", pc, 32'h0); bad++; end
    $display("[mem_timeout] fault, reset mid-MEM, pc=%h", pc);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_add();
    test_load();
    test_branch();
    test_store_wrap();
    test_fetch_ready_wins();
    test_fetch_timeout();
    test_illegal();
    test_misaligned_branch();
    test_mem_timeout_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
